dalign_lsu: RTL and testbench
=============================

DALIGN_LSU -- requirements
Module: dalign_lsu

Interface
REQ-001 Parameter DMEM_BASE, default 32'h0010_0000, byte base address of the data memory window.
REQ-002 Parameter DMEM_SIZE, default 32768, window size in bytes; power of two, at least 8.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Core ports: req_valid in 1; req_ready out 1; req_we in 1; req_size in 2 (01 byte, 10 half, 11 word, 00 illegal); req_unsigned in 1; req_addr in 32; req_wdata in 32.
REQ-006 Response ports: resp_valid out 1; resp_rdata out 32; resp_err out 1.
REQ-007 Memory ports: mem_req out 1; mem_we out 1; mem_addr out 30 (word address); mem_be out 4; mem_wdata out 32; mem_gnt in 1; mem_rvalid in 1; mem_rdata in 32.

Function
REQ-008 Memory lane order: byte at offset k of a word occupies bits [31-8k:24-8k]; mem_be bit (3-k) enables that byte.
REQ-009 FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
REQ-010 req_ready = 1 only in IDLE; a request is accepted when req_valid && req_ready, and all request fields are latched on acceptance.
REQ-011 On acceptance, resp_err is computed: size 00, or any byte of the access outside [DMEM_BASE, DMEM_BASE+DMEM_SIZE), sets error; an erroring request moves to RESP with no memory beat issued.
REQ-012 Otherwise the FSM moves to REQ0; the access is split (needs two beats) when addr[1:0] + bytes > 4.
REQ-013 In REQ0/REQ1, mem_req = 1, and mem_addr, mem_we, mem_be and mem_wdata are held stable until mem_gnt = 1 is sampled.
REQ-014 Beat 0 uses word address addr[31:2]; beat 1 uses addr[31:2]+1 and covers the remaining bytes.
REQ-015 Store: the byte at access index i goes to offset (addr[1:0]+i) mod 4; little-endian source order (req_wdata[7:0] is index 0); mem_be has exactly the bytes written in that beat.
REQ-016 Store beats leave REQx on grant directly to REQ1 (split) or RESP; no rvalid wait.
REQ-017 Load: after grant, go to WAITx; mem_rvalid in WAITx captures that beat's lanes, then go to REQ1 or RESP.
REQ-018 mem_rvalid outside WAIT0/WAIT1 is ignored.
REQ-019 Load result is assembled little-endian and zero-extended when req_unsigned = 1, else sign-extended from the top loaded byte; word loads ignore req_unsigned.
REQ-020 RESP asserts resp_valid for exactly one cycle with resp_rdata (0 for stores and errors) and resp_err, then returns to IDLE.
REQ-021 Minimum latency, aligned load with immediate grant and next-cycle rvalid: accept at T, mem_req at T+1, rvalid at T+2, resp_valid at T+3; an aligned store responds at T+2.
REQ-022 resp_rdata and resp_err hold their values until the next RESP; mem_be = 0 and mem_we = 0 whenever mem_req = 0.

Reset
REQ-023 rst_n low forces, immediately: state IDLE, mem_req 0, resp_valid 0, resp_err 0, resp_rdata 0, mem_be 0, mem_we 0, req_ready 0 while reset is held.
REQ-024 Reset mid-transaction abandons the access with no response; a late mem_rvalid after release is ignored per REQ-018.

Configuration
REQ-025 Macro DALIGN_MISALIGN_EN.
REQ-026 Defined: misaligned accesses are split per REQ-012..017.
REQ-027 Undefined: any access with addr not aligned to its size sets resp_err and issues no beat; REQ1/WAIT1 logic is absent.

Verification
REQ-028 Store word 32'h1122_3344 at 0x0010_0000 -> one beat, mem_addr 0x0004_0000, mem_be 1111, mem_wdata 32'h4433_2211.
REQ-029 Load byte at 0x0010_0003, lane byte 0x80, req_unsigned 0 -> resp_rdata 32'hFFFF_FF80; with req_unsigned 1 -> 32'h0000_0080.
REQ-030 (EN) Load word at 0x0010_0002, words {AA BB CC DD},{EE FF 00 11} -> two beats with mem_addr +1, resp_rdata 32'hFFEE_DDCC.
REQ-031 (EN) Store half 16'hBEEF at 0x0010_0003 -> beat0 mem_be 0001 with lane 0xEF; beat1 mem_be 1000 with lane 0xBE. (no EN) -> resp_err 1, mem_req never asserted.
REQ-032 Load at 0x0020_0000, or size 00 -> resp_err 1 at T+1, no mem_req.
REQ-033 Hold mem_gnt 0 for 5 cycles -> request fields stable; assert rst_n low in WAIT0 -> mem_req 0 at once, no resp_valid, next request serviced normally.

Source files
------------

// File: rtl/dalign_lsu.sv
// -----------------------------------------------------------------------------
// dalign_lsu -- load/store unit between a core request port and a word-wide
// data memory. It handles byte, half-word and word accesses, checks that the
// access lies inside the data memory window, steers bytes onto memory lanes
// and sign- or zero-extends load results.
//
// Memory lane order: byte offset k of a word sits in bits [31-8k:24-8k] and
// is enabled by mem_be[3-k]. Core data is little-endian, so req_wdata[7:0]
// and resp_rdata[7:0] hold the byte at the lowest address.
//
// Build option: define DALIGN_MISALIGN_EN to split accesses that cross a word
// boundary into two memory beats. Without it, any access whose address is not
// aligned to its size returns resp_err and issues no memory beat.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid / req_ready    core request handshake (ready only when idle)
//   req_we, req_size,        store flag, size (01 byte, 10 half, 11 word),
//   req_unsigned, req_addr,  zero-extend flag, byte address,
//   req_wdata                little-endian store data
//   resp_valid, resp_rdata,  one-cycle response pulse, load data (0 for
//   resp_err                 stores and errors), error flag; data/err held
//   mem_req, mem_we,         memory beat request, write enable,
//   mem_addr, mem_be,        word address, byte enables,
//   mem_wdata                lane-ordered store data
//   mem_gnt, mem_rvalid,     beat accepted, read data valid,
//   mem_rdata                lane-ordered read data
// -----------------------------------------------------------------------------
module dalign_lsu #(
  parameter logic [31:0] DMEM_BASE = 32'h0010_0000,
  parameter int unsigned DMEM_SIZE = 32768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  // Latched request fields
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        split;

  logic        ready_q;
  logic        accept;
  logic        req_bad;
  logic        beat1;
  logic [2:0]  nbytes;

  logic [3:0]       lane_en;
  logic [31:0]      lane_wdata;
  logic [3:0][1:0]  lane_idx;    // access byte index carried by lane k
  logic [3:0][7:0]  ld_bytes;    // load bytes captured so far, index order
  logic [3:0][7:0]  ld_merge;    // ld_bytes plus the lanes arriving now
  logic [31:0]      ld_result;

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    logic [2:0] n;
    case (s)
      2'b01:   n = 3'd1;
      2'b10:   n = 3'd2;
      2'b11:   n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // Error check: illegal size, any byte outside the window, or (without
  // split support) an address not aligned to the access size.
  function automatic logic access_bad(input logic [1:0] s, input logic [31:0] a);
    logic [32:0] first;
    logic [32:0] last;
    logic [32:0] lo;
    logic [32:0] hi;
    logic        bad;
    first = {1'b0, a};
    last  = first + {30'd0, size_bytes(s)} - 33'd1;
    lo    = {1'b0, DMEM_BASE};
    hi    = lo + 33'(DMEM_SIZE);
    bad   = (s == 2'b00) || (first < lo) || (last >= hi);
`ifndef DALIGN_MISALIGN_EN
    bad = bad || ((s == 2'b10) && a[0]) || ((s == 2'b11) && (a[1:0] != 2'b00));
`endif
    return bad;
  endfunction

  assign req_ready = ready_q;
  assign accept    = (state == IDLE) && req_valid && ready_q;
  assign req_bad   = access_bad(req_size, req_addr);
  assign nbytes    = size_bytes(size_q);

`ifdef DALIGN_MISALIGN_EN
  assign beat1 = (state == REQ1) || (state == WAIT1);
`else
  assign beat1 = 1'b0;
  assign split = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = req_bad ? RESP : REQ0;
        end else begin
          state_next = IDLE;
        end
      end
      REQ0: begin
        if (mem_gnt) begin
          if (!we_q)      state_next = WAIT0;
          else if (split) state_next = REQ1;
          else            state_next = RESP;
        end else begin
          state_next = REQ0;
        end
      end
      WAIT0: begin
        if (mem_rvalid) begin
          state_next = split ? REQ1 : RESP;
        end else begin
          state_next = WAIT0;
        end
      end
`ifdef DALIGN_MISALIGN_EN
      REQ1: begin
        if (mem_gnt) begin
          state_next = we_q ? RESP : WAIT1;
        end else begin
          state_next = REQ1;
        end
      end
      WAIT1: begin
        if (mem_rvalid) begin
          state_next = RESP;
        end else begin
          state_next = WAIT1;
        end
      end
`endif
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane steering for the current beat: which lanes belong to it and which
  // access byte each lane carries. Beat 0 starts at offset addr[1:0]; beat 1
  // starts at offset 0 of the next word with index 4-addr[1:0].
  always_comb begin
    logic [2:0] off;
    logic [2:0] idx;
    logic       hit;
    lane_en    = 4'b0000;
    lane_wdata = 32'h0000_0000;
    lane_idx   = 8'h00;
    off        = 3'd0;
    idx        = 3'd0;
    hit        = 1'b0;
    for (int k = 0; k < 4; k++) begin
      off = 3'(k);
      if (beat1) begin
        idx = off + 3'd4 - {1'b0, addr_q[1:0]};
        hit = (idx < nbytes);
      end else begin
        idx = off - {1'b0, addr_q[1:0]};
        hit = (off >= {1'b0, addr_q[1:0]}) && (idx < nbytes);
      end
      lane_idx[k] = idx[1:0];
      if (hit) begin
        lane_en[3-k]             = 1'b1;
        lane_wdata[31-8*k -: 8]  = wdata_q[{idx[1:0], 3'b000} +: 8];
      end else begin
        lane_en[3-k]             = 1'b0;
      end
    end
  end

  // Merge incoming read lanes into the load byte buffer
  always_comb begin
    ld_merge = ld_bytes;
    if (((state == WAIT0) || (state == WAIT1)) && mem_rvalid) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[3-k]) begin
          ld_merge[lane_idx[k]] = mem_rdata[31-8*k -: 8];
        end else begin
          ld_merge[lane_idx[k]] = ld_merge[lane_idx[k]];
        end
      end
    end else begin
      ld_merge = ld_bytes;
    end
  end

  // Load result extension from the top loaded byte
  always_comb begin
    case (size_q)
      2'b01:   ld_result = uns_q ? {24'h00_0000, ld_merge[0]}
                                 : {{24{ld_merge[0][7]}}, ld_merge[0]};
      2'b10:   ld_result = uns_q ? {16'h0000, ld_merge[1], ld_merge[0]}
                                 : {{16{ld_merge[1][7]}}, ld_merge[1], ld_merge[0]};
      2'b11:   ld_result = ld_merge;
      default: ld_result = 32'h0000_0000;
    endcase
  end

  assign mem_req   = (state == REQ0) || (state == REQ1);
  assign mem_we    = mem_req & we_q;
  assign mem_be    = mem_req ? lane_en : 4'b0000;
  assign mem_wdata = mem_req ? lane_wdata : 32'h0000_0000;
  assign mem_addr  = beat1 ? (addr_q[31:2] + 30'd1) : addr_q[31:2];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Ready is low during reset and high in every IDLE cycle after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= (state_next == IDLE);
  end

  // Request capture on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
    end else if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end else begin
      we_q    <= we_q;
    end
  end

`ifdef DALIGN_MISALIGN_EN
  // Split flag: access runs past the end of its first word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      split <= 1'b0;
    else if (accept) split <= ({1'b0, req_addr[1:0]} + size_bytes(req_size)) > 3'd4;
    else             split <= split;
  end
`endif

  // Load byte buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ld_bytes <= 32'h0000_0000;
    else        ld_bytes <= ld_merge;
  end

  // Response registers; data and error are only updated on entry to RESP.
  // The only IDLE->RESP path is a rejected request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0000_0000;
    end else begin
      resp_valid <= (state_next == RESP);
      if ((state_next == RESP) && (state != RESP)) begin
        resp_err   <= (state == IDLE);
        resp_rdata <= ((state == IDLE) || we_q) ? 32'h0000_0000 : ld_result;
      end else begin
        resp_err   <= resp_err;
        resp_rdata <= resp_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dalign_lsu.sv
module tb_dalign_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  dalign_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    int          nb;
    logic [29:0] ma0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] rd0;
    logic [29:0] ma1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic [31:0] rd1;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input int nb,
                              input logic [29:0] ma0, input logic [3:0] be0,
                              input logic [31:0] wd0, input logic [31:0] rd0,
                              input logic [29:0] ma1, input logic [3:0] be1,
                              input logic [31:0] wd1, input logic [31:0] rd1,
                              input logic [31:0] rdata);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.err = err; v.nb = nb; v.ma0 = ma0; v.be0 = be0; v.wd0 = wd0; v.rd0 = rd0;
    v.ma1 = ma1; v.be1 = be1; v.wd1 = wd1; v.rd1 = rd1; v.rdata = rdata;
    return v;
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and act as the memory for each expected beat
  task automatic run(input vec_t v, input string nm);
    logic [29:0] ma;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    chk({nm, " ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    step();
    req_valid = 1'b0;
    if (v.err) begin
      chk({nm, " err mem_req"}, {31'd0, mem_req}, 32'd0);
      chk({nm, " err resp_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({nm, " err resp_err"}, {31'd0, resp_err}, 32'd1);
      chk({nm, " err resp_rdata"}, resp_rdata, 32'h0);
      step();
      chk({nm, " err pulse end"}, {31'd0, resp_valid}, 32'd0);
      chk({nm, " err no mem_req"}, {31'd0, mem_req}, 32'd0);
    end else begin
      for (int b = 0; b < v.nb; b++) begin
        ma = (b == 0) ? v.ma0 : v.ma1;
        be = (b == 0) ? v.be0 : v.be1;
        wd = (b == 0) ? v.wd0 : v.wd1;
        rd = (b == 0) ? v.rd0 : v.rd1;
        chk($sformatf("%s b%0d mem_req", nm, b), {31'd0, mem_req}, 32'd1);
        chk($sformatf("%s b%0d mem_addr", nm, b), {2'b00, mem_addr}, {2'b00, ma});
        chk($sformatf("%s b%0d mem_we", nm, b), {31'd0, mem_we}, {31'd0, v.we});
        if (v.we) begin
          chk($sformatf("%s b%0d mem_be", nm, b), {28'd0, mem_be}, {28'd0, be});
          chk($sformatf("%s b%0d mem_wdata", nm, b), mem_wdata & be_mask(be), wd);
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        if (!v.we) begin
          chk($sformatf("%s b%0d wait mem_req", nm, b), {31'd0, mem_req}, 32'd0);
          chk($sformatf("%s b%0d wait mem_be", nm, b), {28'd0, mem_be}, 32'd0);
          mem_rvalid = 1'b1; mem_rdata = rd;
          step();
          mem_rvalid = 1'b0; mem_rdata = 32'h0;
        end
      end
      chk({nm, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({nm, " resp_err"}, {31'd0, resp_err}, 32'd0);
      chk({nm, " resp_rdata"}, resp_rdata, v.rdata);
      chk({nm, " resp mem_req"}, {31'd0, mem_req}, 32'd0);
      step();
      chk({nm, " pulse end"}, {31'd0, resp_valid}, 32'd0);
      chk({nm, " rdata hold"}, resp_rdata, v.rdata);
    end
  endtask

  initial begin
    vec_t sv;
    // we size uns addr wdata err nb ma0 be0 wd0 rd0 ma1 be1 wd1 rd1 rdata
    tbl[0]  = mk(1'b1, 2'b11, 1'b0, 32'h0010_0000, 32'h1122_3344, 1'b0, 1, 30'h0004_0000, 4'b1111, 32'h4433_2211, 32'h0, 30'h0, 4'h0, 32'h0, 32'h0, 32'h0);
    tbl[1]  = mk(1'b0, 2'b01, 1'b0, 32'h0010_0003, 32'h0, 1'b0, 1, 30'h0004_0000, 4'h0, 32'h0, 32'h1234_5680, 30'h0, 4'h0, 32'h0, 32'h0, 32'hFFFF_FF80);
    tbl[2]  = mk(1'b0, 2'b01, 1'b1, 32'h0010_0003, 32'h0, 1'b0, 1, 30'h0004_0000, 4'h0, 32'h0, 32'h1234_5680, 30'h0, 4'h0, 32'h0, 32'h0, 32'h0000_0080);
    tbl[3]  = mk(1'b0, 2'b10, 1'b0, 32'h0010_0002, 32'h0, 1'b0, 1, 30'h0004_0000, 4'h0, 32'h0, 32'h1122_F0E1, 30'h0, 4'h0, 32'h0, 32'h0, 32'hFFFF_E1F0);
    tbl[4]  = mk(1'b0, 2'b10, 1'b1, 32'h0010_0004, 32'h0, 1'b0, 1, 30'h0004_0001, 4'h0, 32'h0, 32'h8899_AABB, 30'h0, 4'h0, 32'h0, 32'h0, 32'h0000_9988);
    tbl[5]  = mk(1'b0, 2'b11, 1'b1, 32'h0010_0008, 32'h0, 1'b0, 1, 30'h0004_0002, 4'h0, 32'h0, 32'hAABB_CCDD, 30'h0, 4'h0, 32'h0, 32'h0, 32'hDDCC_BBAA);
    tbl[6]  = mk(1'b1, 2'b01, 1'b0, 32'h0010_0001, 32'h1234_56A5, 1'b0, 1, 30'h0004_0000, 4'b0100, 32'h00A5_0000, 32'h0, 30'h0, 4'h0, 32'h0, 32'h0, 32'h0);
    tbl[7]  = mk(1'b1, 2'b10, 1'b0, 32'h0010_0006, 32'h0000_BEEF, 1'b0, 1, 30'h0004_0001, 4'b0011, 32'h0000_EFBE, 32'h0, 30'h0, 4'h0, 32'h0, 32'h0, 32'h0);
    tbl[8]  = mk(1'b0, 2'b01, 1'b0, 32'h0010_7FFF, 32'h0, 1'b0, 1, 30'h0004_1FFF, 4'h0, 32'h0, 32'h0000_007F, 30'h0, 4'h0, 32'h0, 32'h0, 32'h0000_007F);
    tbl[9]  = mk(1'b0, 2'b10, 1'b0, 32'h0010_7FFE, 32'h0, 1'b0, 1, 30'h0004_1FFF, 4'h0, 32'h0, 32'h0000_7FFE, 30'h0, 4'h0, 32'h0, 32'h0, 32'hFFFF_FE7F);
    tbl[10] = mk(1'b1, 2'b01, 1'b0, 32'h0010_0000, 32'hFFFF_FF5A, 1'b0, 1, 30'h0004_0000, 4'b1000, 32'h5A00_0000, 32'h0, 30'h0, 4'h0, 32'h0, 32'h0, 32'h0);
    tbl[11] = mk(1'b0, 2'b11, 1'b0, 32'h0020_0000, 32'h0, 1'b1, 0, 30'h0, 4'h0, 32'h0, 32'h0, 30'h0, 4'h0, 32'h0, 32'h0, 32'h0);
    tbl[12] = mk(1'b0, 2'b00, 1'b0, 32'h0010_0000, 32'h0, 1'b1, 0, 30'h0, 4'h0, 32'h0, 32'h0, 30'h0, 4'h0, 32'h0, 32'h0, 32'h0);
    tbl[13] = mk(1'b1, 2'b11, 1'b0, 32'h0010_8000, 32'h5555_AAAA, 1'b1, 0, 30'h0, 4'h0, 32'h0, 32'h0, 30'h0, 4'h0, 32'h0, 32'h0, 32'h0);
    tbl[14] = mk(1'b0, 2'b11, 1'b0, 32'h000F_FFFC, 32'h0, 1'b1, 0, 30'h0, 4'h0, 32'h0, 32'h0, 30'h0, 4'h0, 32'h0, 32'h0, 32'h0);
    tbl[15] = mk(1'b0, 2'b11, 1'b0, 32'h0010_7FFE, 32'h0, 1'b1, 0, 30'h0, 4'h0, 32'h0, 32'h0, 30'h0, 4'h0, 32'h0, 32'h0, 32'h0);

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    #2;
    chk("reset req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset resp_err", {31'd0, resp_err}, 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'h0);
    chk("reset mem_be", {28'd0, mem_be}, 32'd0);
    chk("reset mem_we", {31'd0, mem_we}, 32'd0);
    repeat (3) step();
    chk("reset held ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      run(tbl[i], $sformatf("v%0d", i));
    end

    // Word-boundary crossing accesses
`ifdef DALIGN_MISALIGN_EN
    sv = mk(1'b0, 2'b11, 1'b0, 32'h0010_0002, 32'h0, 1'b0, 2, 30'h0004_0000, 4'h0, 32'h0, 32'hAABB_CCDD, 30'h0004_0001, 4'h0, 32'h0, 32'hEEFF_0011, 32'hFFEE_DDCC);
    run(sv, "split load word");
    sv = mk(1'b1, 2'b10, 1'b0, 32'h0010_0003, 32'h0000_BEEF, 1'b0, 2, 30'h0004_0000, 4'b0001, 32'h0000_00EF, 32'h0, 30'h0004_0001, 4'b1000, 32'hBE00_0000, 32'h0, 32'h0);
    run(sv, "split store half");
`else
    sv = mk(1'b0, 2'b11, 1'b0, 32'h0010_0002, 32'h0, 1'b1, 0, 30'h0, 4'h0, 32'h0, 32'h0, 30'h0, 4'h0, 32'h0, 32'h0, 32'h0);
    run(sv, "misaligned load word");
    sv = mk(1'b1, 2'b10, 1'b0, 32'h0010_0003, 32'h0000_BEEF, 1'b1, 0, 30'h0, 4'h0, 32'h0, 32'h0, 30'h0, 4'h0, 32'h0, 32'h0, 32'h0);
    run(sv, "misaligned store half");
`endif

    // Grant stall: request fields stay stable, stray rvalid is ignored
    chk("stall ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b11; req_unsigned = 1'b0;
    req_addr = 32'h0010_0010; req_wdata = 32'hCAFE_F00D;
    step();
    req_valid = 1'b0; req_wdata = 32'h0; req_addr = 32'h0;
    for (int c = 0; c < 5; c++) begin
      mem_rvalid = (c == 2);
      chk($sformatf("stall c%0d mem_req", c), {31'd0, mem_req}, 32'd1);
      chk($sformatf("stall c%0d mem_addr", c), {2'b00, mem_addr}, 32'h0004_0004);
      chk($sformatf("stall c%0d mem_be", c), {28'd0, mem_be}, 32'h0000_000F);
      chk($sformatf("stall c%0d mem_wdata", c), mem_wdata, 32'h0DF0_FECA);
      chk($sformatf("stall c%0d mem_we", c), {31'd0, mem_we}, 32'd1);
      chk($sformatf("stall c%0d resp_valid", c), {31'd0, resp_valid}, 32'd0);
      step();
    end
    mem_rvalid = 1'b0;
    mem_gnt = 1'b1;
    chk("stall final mem_req", {31'd0, mem_req}, 32'd1);
    step();
    mem_gnt = 1'b0;
    chk("stall resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("stall resp_rdata", resp_rdata, 32'h0);
    chk("stall resp_err", {31'd0, resp_err}, 32'd0);
    step();

    // Leave a non-zero response behind, then reset in the middle of a load
    run(tbl[1], "pre-reset load");
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; req_addr = 32'h0010_0000;
    step();
    req_valid = 1'b0;
    chk("rst seq mem_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("rst seq wait0", {31'd0, mem_req}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid reset mem_req", {31'd0, mem_req}, 32'd0);
    chk("mid reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid reset req_ready", {31'd0, req_ready}, 32'd0);
    chk("mid reset resp_rdata", resp_rdata, 32'h0);
    chk("mid reset resp_err", {31'd0, resp_err}, 32'd0);
    chk("mid reset mem_be", {28'd0, mem_be}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("late rvalid c%0d resp_valid", c), {31'd0, resp_valid}, 32'd0);
      chk($sformatf("late rvalid c%0d mem_req", c), {31'd0, mem_req}, 32'd0);
      step();
    end
    run(tbl[0], "after reset store");
    run(tbl[3], "after reset load");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
